// File: rtl/sonic_vc_pkg.sv
// Shared types and constants for the two-output virtual-channel demultiplexer.
// Statistics counters are enabled by defining SONIC_VC_DEMUX_STATS_EN.
package sonic_vc_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 128;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

  // Sideband bits carried alongside data: error, sop, eop, empty.
  localparam int unsigned SIDEBAND_W = 4;

  localparam int unsigned ERR_CH_CHANGE = 0;
  localparam int unsigned ERR_ORPHAN    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/sonic_vc_demultiplexer_stage.sv
// Single-entry registered output slot with valid/ready handshake.
// Accepts a new beat whenever empty or draining in the same cycle.
module sonic_vc_demultiplexer_stage
  import sonic_vc_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = DEF_DATA_WIDTH + SIDEBAND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  input  logic                     out_ready_i
);

  logic                     valid_q, valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;

  always_comb begin
    ready_o   = out_ready_i || !valid_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/sonic_vc_demultiplexer.sv
// Packet-aware 1-to-2 stream demultiplexer with sticky error status.
// Per-output packet counters exist only when SONIC_VC_DEMUX_STATS_EN is defined.
module sonic_vc_demultiplexer
  import sonic_vc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_channel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_error,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  in_empty,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_error,
  output logic                  out0_startofpacket,
  output logic                  out0_endofpacket,
  output logic                  out0_empty,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_error,
  output logic                  out1_startofpacket,
  output logic                  out1_endofpacket,
  output logic                  out1_empty,
  output logic [1:0]            err_status,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

  localparam int unsigned PW = DATA_WIDTH + SIDEBAND_W;

  pkt_state_e state_q, state_d;
  logic       lock_q, lock_d;
  logic [1:0] err_q, err_d;

  logic          dest, orphan, fire, load0, load1, ch_change;
  logic          st0_ready, st1_ready;
  logic [PW-1:0] in_payload, out0_payload, out1_payload;

  assign in_payload = {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};

  // Orphans are swallowed unconditionally so they can never be stalled by a full slot.
  always_comb begin
    dest   = (state_q == PKT) ? lock_q : in_channel;
    orphan = (state_q == IDLE) && in_valid && !in_startofpacket;
    if (orphan) begin
      in_ready = 1'b1;
    end else begin
      in_ready = dest ? st1_ready : st0_ready;
    end
    fire      = in_valid && in_ready;
    load0     = fire && !orphan && !dest;
    load1     = fire && !orphan && dest;
    ch_change = fire && (state_q == PKT) && (in_channel != lock_q);
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (fire && !orphan) begin
          lock_d = in_channel;
          if (!in_endofpacket) state_d = PKT;
        end
      end
      PKT: begin
        if (fire && in_endofpacket) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear is applied first so a coincident error event still lands.
  always_comb begin
    err_d = err_clr ? '0 : err_q;
    if (ch_change)      err_d[ERR_CH_CHANGE] = 1'b1;
    if (fire && orphan) err_d[ERR_ORPHAN]    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign err_status = err_q;

  sonic_vc_demultiplexer_stage #(
    .PAYLOAD_WIDTH(PW)
  ) u_stage0 (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load0),
    .payload_i  (in_payload),
    .ready_o    (st0_ready),
    .valid_o    (out0_valid),
    .payload_o  (out0_payload),
    .out_ready_i(out0_ready)
  );

  sonic_vc_demultiplexer_stage #(
    .PAYLOAD_WIDTH(PW)
  ) u_stage1 (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load1),
    .payload_i  (in_payload),
    .ready_o    (st1_ready),
    .valid_o    (out1_valid),
    .payload_o  (out1_payload),
    .out_ready_i(out1_ready)
  );

  assign {out0_data, out0_error, out0_startofpacket, out0_endofpacket, out0_empty} = out0_payload;
  assign {out1_data, out1_error, out1_startofpacket, out1_endofpacket, out1_empty} = out1_payload;

`ifdef SONIC_VC_DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid && out0_ready && out0_endofpacket) cnt0_d = cnt0_q + CNT_WIDTH'(1);
    if (out1_valid && out1_ready && out1_endofpacket) cnt1_d = cnt1_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_sonic_vc_demultiplexer.sv
// Self-checking bench for sonic_vc_demultiplexer: queue-based reference model
// compared every cycle, plus literal checks on directed scenarios.
module tb_sonic_vc_demultiplexer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;
  localparam int unsigned PW = DW + 4;
`ifdef SONIC_VC_DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, reset;
  logic in_valid, in_ready, in_channel, in_error, in_sop, in_eop, in_empty;
  logic [DW-1:0] in_data;
  logic out0_valid, out0_ready, out0_error, out0_sop, out0_eop, out0_empty;
  logic out1_valid, out1_ready, out1_error, out1_sop, out1_eop, out1_empty;
  logic [DW-1:0] out0_data, out1_data;
  logic [1:0] err_status;
  logic err_clr;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  sonic_vc_demultiplexer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
    .in_data(in_data), .in_error(in_error), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .in_empty(in_empty),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out0_error(out0_error), .out0_startofpacket(out0_sop),
    .out0_endofpacket(out0_eop), .out0_empty(out0_empty),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out1_error(out1_error), .out1_startofpacket(out1_sop),
    .out1_endofpacket(out1_eop), .out1_empty(out1_empty),
    .err_status(err_status), .err_clr(err_clr),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each output is a FIFO of beats not yet taken downstream.
  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];
  bit m_in_pkt, m_lock, m_dest, m_orph, m_ot0, m_ot1, m_rdy, m_fire;
  bit [1:0] m_err;
  int unsigned m_c0, m_c1;

  always @(negedge clk) begin
    if (reset) begin
      q0.delete(); q1.delete();
      m_in_pkt = 0; m_lock = 0; m_err = 0; m_c0 = 0; m_c1 = 0;
    end
    m_dest = m_in_pkt ? m_lock : in_channel;
    m_orph = !m_in_pkt && in_valid && !in_sop;
    m_ot0  = (q0.size() != 0) && out0_ready;
    m_ot1  = (q1.size() != 0) && out1_ready;
    m_rdy  = m_orph || (m_dest ? (q1.size() == 0 || m_ot1) : (q0.size() == 0 || m_ot0));
    m_fire = in_valid && m_rdy;

    check("in_ready", in_ready, m_rdy);
    check("out0_valid", out0_valid, q0.size() != 0);
    check("out1_valid", out1_valid, q1.size() != 0);
    if (q0.size() != 0)
      check("out0_beat", {out0_data, out0_error, out0_sop, out0_eop, out0_empty}, q0[0]);
    if (q1.size() != 0)
      check("out1_beat", {out1_data, out1_error, out1_sop, out1_eop, out1_empty}, q1[0]);
    check("err_status", err_status, m_err);
    check("pkt_cnt0", pkt_cnt0, m_c0);
    check("pkt_cnt1", pkt_cnt1, m_c1);

    if (!reset) begin
      if (m_ot0) begin
        if (STATS && q0[0][1]) m_c0++;
        void'(q0.pop_front());
      end
      if (m_ot1) begin
        if (STATS && q1[0][1]) m_c1++;
        void'(q1.pop_front());
      end
      if (err_clr) m_err = 0;
      if (m_fire) begin
        if (m_orph) begin
          m_err[1] = 1;
        end else begin
          if (m_dest) q1.push_back({in_data, in_error, in_sop, in_eop, in_empty});
          else        q0.push_back({in_data, in_error, in_sop, in_eop, in_empty});
          if (m_in_pkt && in_channel != m_lock) m_err[0] = 1;
          if (!m_in_pkt) begin
            m_lock   = in_channel;
            m_in_pkt = !in_eop;
          end else if (in_eop) begin
            m_in_pkt = 0;
          end
        end
      end
    end
  end

  bit watch0, seen0;
  always @(negedge clk) if (watch0 && out0_valid) seen0 = 1;

  int unsigned last_cycles;

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit ch, input logic [DW-1:0] d, input bit sop, input bit eop,
                      input bit er, input bit emp);
    bit acc;
    acc = 0;
    in_valid = 1; in_channel = ch; in_data = d;
    in_sop = sop; in_eop = eop; in_error = er; in_empty = emp;
    last_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      last_cycles++;
      if (acc) break;
    end
    check("accept_timeout", acc, 1'b1);
    in_valid = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    idle(2);
    reset = 0;
  endtask

  int unsigned cyc;

  initial begin
    reset = 1; in_valid = 0; in_channel = 0; in_data = '0; in_error = 0;
    in_sop = 0; in_eop = 0; in_empty = 0; err_clr = 0;
    out0_ready = 1; out1_ready = 1; watch0 = 0; seen0 = 0;
    #1;
    check("rst_out0_valid", out0_valid, 1'b0);
    check("rst_out1_valid", out1_valid, 1'b0);
    check("rst_out0_data", out0_data, 16'h0);
    check("rst_err", err_status, 2'b00);
    check("rst_cnt1", pkt_cnt1, 0);
    idle(2);
    reset = 0;

    // 3-beat packet to channel 1
    watch0 = 1;
    send(1, 16'h1001, 1, 0, 0, 0);
    send(1, 16'h1002, 0, 0, 1, 0);
    send(1, 16'h1003, 0, 1, 0, 1);
    idle(2);
    watch0 = 0;
    check("c1_out0_never", seen0, 1'b0);
    check("c1_cnt1", pkt_cnt1, STATS ? 1 : 0);

    // out0 stalled and full; channel 1 traffic must flow
    out0_ready = 0;
    send(0, 16'hA0A0, 1, 1, 0, 0);
    cyc = 0;
    send(1, 16'h2001, 1, 0, 0, 0); cyc += last_cycles;
    send(1, 16'h2002, 0, 0, 0, 0); cyc += last_cycles;
    send(1, 16'h2003, 0, 1, 0, 0); cyc += last_cycles;
    check("bp_cycles", cyc, 3);
    idle(2);
    check("bp_out0_valid", out0_valid, 1'b1);
    check("bp_out0_data", out0_data, 16'hA0A0);
    out0_ready = 1;
    idle(2);

    // alternating single-beat packets at full rate
    pulse_reset();
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send(i[0], 16'h3000 + 16'(i), 1, 1, 0, 0);
      cyc += last_cycles;
    end
    idle(2);
    check("alt_cycles", cyc, 8);
    check("alt_cnt0", pkt_cnt0, STATS ? 4 : 0);
    check("alt_cnt1", pkt_cnt1, STATS ? 4 : 0);

    // channel change mid-packet stays on locked output
    send(0, 16'h0331, 1, 0, 0, 0);
    send(1, 16'h0332, 0, 0, 0, 0);
    send(0, 16'h0333, 1, 0, 0, 0);
    send(0, 16'h0334, 0, 1, 0, 0);
    idle(2);
    check("chg_err", err_status, 2'b01);

    // orphan coincident with clear: set wins, other bit clears
    err_clr = 1;
    send(0, 16'h0340, 0, 0, 0, 0);
    err_clr = 0;
    check("clr_set_wins", err_status, 2'b10);
    err_clr = 1; idle(1); err_clr = 0;
    check("clr_err", err_status, 2'b00);

    // lone orphan beat
    send(1, 16'h0350, 0, 1, 0, 0);
    idle(1);
    check("orph_err", err_status, 2'b10);
    check("orph_out1_valid", out1_valid, 1'b0);
    err_clr = 1; idle(1); err_clr = 0;

    // reset mid-packet, then a fresh packet
    send(1, 16'h5101, 1, 0, 0, 0);
    send(1, 16'h5102, 0, 0, 0, 0);
    reset = 1;
    #1;
    check("mid_rst_out1_valid", out1_valid, 1'b0);
    check("mid_rst_out1_data", out1_data, 16'h0);
    idle(1);
    reset = 0;
    send(1, 16'h5103, 0, 1, 0, 0);
    idle(1);
    check("post_rst_orphan", err_status, 2'b10);
    send(1, 16'h5201, 1, 0, 0, 0);
    send(1, 16'h5202, 0, 0, 0, 0);
    send(1, 16'h5203, 0, 1, 0, 0);
    idle(3);
    check("post_rst_cnt1", pkt_cnt1, STATS ? 1 : 0);
    check("post_rst_cnt0", pkt_cnt0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonic_vc_demultiplexer.md
SONIC_VC_DEMULTIPLEXER -- requirements
Module: sonic_vc_demultiplexer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, stream data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, packet counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid/in_ready  input/output  1/1  upstream handshake.
REQ-006 SHALL have port in_channel  input  1  destination output for the beat (0 -> out0, 1 -> out1).
REQ-007 SHALL have ports in_data  input  DATA_WIDTH, and in_error, in_startofpacket, in_endofpacket, in_empty  input  1 each  beat payload.
REQ-008 SHALL have, for k in {0,1}: outk_valid  output  1; outk_ready  input  1; outk_data  output  DATA_WIDTH; outk_error, outk_startofpacket, outk_endofpacket, outk_empty  output  1 each.
REQ-009 SHALL have port err_status  output  2  sticky status: bit0 channel changed mid-packet, bit1 orphan beat dropped.
REQ-010 SHALL have port err_clr  input  1  single-cycle clear of err_status.
REQ-011 SHALL have ports pkt_cnt0, pkt_cnt1  output  CNT_WIDTH each  packets delivered per output.

Function
REQ-012 Beat transfer on in_valid && in_ready; outk transfer on outk_valid && outk_ready.
REQ-013 Packet FSM states IDLE, PKT; IDLE -> PKT on accepted beat with SOP and no EOP; PKT -> IDLE on accepted beat with EOP; SOP+EOP in IDLE stays IDLE.
REQ-014 Accepted SOP beat in IDLE: route by in_channel, latch it as locked channel.
REQ-015 In PKT: route by locked channel, ignore in_channel; accepted beat with in_channel != locked channel sets err_status[0], beat still forwarded.
REQ-016 Accepted SOP beat in PKT: treated as continuation (forwarded to locked channel), no state change unless EOP.
REQ-017 Accepted non-SOP beat in IDLE: orphan; in_ready=1, beat discarded, sets err_status[1], no output activity.
REQ-018 in_ready = ready of the destination output stage (IDLE: stage in_channel; PKT: locked stage); in IDLE with in_valid && !in_startofpacket, in_ready=1.
REQ-019 Each output stage: one registered slot; stage ready = outk_ready || !outk_valid; latency exactly 1 cycle in->out; full throughput with outk_ready held high.
REQ-020 Stage loads payload when its input beat transfers; outk_valid clears on outk_ready with no new load; valid/payload held stable while outk_valid && !outk_ready.
REQ-021 Backpressure on one output SHALL NOT stall beats routed to the other output.
REQ-022 err_status bits sticky; err_clr clears both; set event coincident with err_clr: set wins.
REQ-023 pkt_cntk increments by 1 per outk transfer with outk_endofpacket; wraps modulo 2^CNT_WIDTH.

Reset
REQ-024 On reset assertion, immediately: FSM IDLE, locked channel 0, all outk_valid 0, outk payload 0, err_status 0, pkt_cnt0/1 0.
REQ-025 Reset mid-packet SHALL discard in-flight beats and partial packets; first beat after release needs SOP.

Configuration
REQ-026 With SONIC_VC_DEMUX_STATS_EN defined: pkt_cnt0/1 implemented per REQ-023.
REQ-027 Without SONIC_VC_DEMUX_STATS_EN: no counter registers; pkt_cnt0/1 tied to 0; ports retained.

Structure
REQ-028 Shared package sonic_vc_pkg SHALL hold FSM state typedef (IDLE, PKT), err_status bit index constants, default DATA_WIDTH/CNT_WIDTH.
REQ-029 Output slot SHALL be sub-module sonic_vc_demultiplexer_stage (parameter PAYLOAD_WIDTH = DATA_WIDTH+4), instantiated twice.

Verification
REQ-030 3-beat packet, channel 1, out1_ready=1 -> out1 beats 1 cycle later, out0_valid never 1, pkt_cnt1=1.
REQ-031 Single-beat SOP+EOP packets alternating channel 0/1 each cycle, both readies 1 -> in_ready constant 1, pkt_cnt0=pkt_cnt1=N/2.
REQ-032 out0_ready=0 with out0 slot full, packet to channel 1 -> in_ready=1, out1 receives all beats; out0 data unchanged.
REQ-033 4-beat packet locked on 0, in_channel=1 on beat 2 -> all 4 beats on out0, err_status=2'b01; err_clr -> 2'b00.
REQ-034 Non-SOP beat in IDLE -> consumed, no outk_valid, err_status[1]=1.
REQ-035 Reset asserted after beat 2 of 4-beat packet -> outputs zero same cycle; new SOP packet on channel 1 delivered intact.
